// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache arbiter slice.
//   lc3b_word   : 16-bit address/word type
//   lc3b_c_line : 128-bit cache line type
//   arb_state_t : arbiter FSM states
//   owner_t     : which cache was granted most recently
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_c_line;

    typedef enum logic [1:0] {
        IDLE,
        I_BUSY,
        D_BUSY
    } arb_state_t;

    typedef enum logic {
        OWNER_I,
        OWNER_D
    } owner_t;

endpackage

// File: rtl/cache_arbiter_pick.sv
// arb_pick: combinational grant selection between I-cache and D-cache.
//   i_req      : I-cache has a pending fill request
//   d_req      : D-cache has a pending fill or writeback request
//   last_grant : cache served most recently (round-robin history)
//   grant_i    : I-cache wins this arbitration
//   grant_d    : D-cache wins this arbitration
// Macro ARB_DCACHE_PRIO_EN: ties always go to the D-cache and last_grant is
// not consulted. Undefined: ties go to the cache not served last.
module arb_pick
    import lc3b_types::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  owner_t last_grant,
    output logic   grant_i,
    output logic   grant_d
);

    logic tie_to_d;

`ifdef ARB_DCACHE_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = (last_grant == OWNER_D);
    assign tie_to_d = 1'b1;
`else
    assign tie_to_d = (last_grant == OWNER_I);
`endif

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (i_req && d_req) begin
            grant_d = tie_to_d;
            grant_i = !tie_to_d;
        end else begin
            grant_i = i_req;
            grant_d = d_req;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical memory port between I-cache and D-cache.
//   clk, reset                 : clock, async active-high reset
//   icache_read/addr           : I-cache fill request (held until icache_resp)
//   icache_rdata/resp          : fill data and one-cycle completion pulse
//   dcache_read/write/addr     : D-cache fill/writeback request (held until resp)
//   dcache_wdata               : writeback line
//   dcache_rdata/resp          : fill data and one-cycle completion pulse
//   pmem_read/write/address    : registered memory command, held until pmem_resp
//   pmem_wdata                 : registered writeback line
//   pmem_rdata/resp            : memory return data and completion
// Macro ARB_DCACHE_PRIO_EN selects fixed D-cache priority on ties
// (default: round-robin).
module cache_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_addr,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t        state;
    owner_t            last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              grant_i;
    logic              grant_d;

    arb_pick u_pick (
        .i_req      (icache_read),
        .d_req      (dcache_read | dcache_write),
        .last_grant (last_grant),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= OWNER_D;
            addr_q     <= '0;
            wdata_q    <= '0;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state      <= I_BUSY;
                        last_grant <= OWNER_I;
                        addr_q     <= icache_addr;
                        pmem_read  <= 1'b1;
                        pmem_write <= 1'b0;
                    end else if (grant_d) begin
                        state      <= D_BUSY;
                        last_grant <= OWNER_D;
                        addr_q     <= dcache_addr;
                        wdata_q    <= dcache_wdata;
                        // A simultaneous read is dropped in favour of the writeback.
                        pmem_write <= dcache_write;
                        pmem_read  <= !dcache_write;
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (pmem_resp) begin
                        state      <= IDLE;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // Completion is forwarded in the same cycle memory answers.
    assign icache_resp  = (state == I_BUSY) && pmem_resp;
    assign dcache_resp  = (state == D_BUSY) && pmem_resp;
    assign icache_rdata = pmem_rdata;
    assign dcache_rdata = pmem_rdata;

endmodule
